// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a 5-stage in-order pipeline: tracks EX/MEM/WB destinations,
// raises load-use / stall-only stalls and branch flushes, and selects forwarded operands.
module pipe_hazard_ctrl #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned FWD_EN = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid_i,
   input  logic              id_use_rs_i,
   input  logic              id_use_rt_i,
   input  logic              id_wb_en_i,
   input  logic              id_is_load_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic [REG_AW-1:0] id_dest_i,
   input  logic              ex_br_taken_i,
   input  logic [DATA_W-1:0] ex_rs_data_i,
   input  logic [DATA_W-1:0] ex_rt_data_i,
   input  logic [DATA_W-1:0] mem_alu_data_i,
   input  logic [DATA_W-1:0] wb_data_i,
   output logic              stall_o,
   output logic              flush_o,
   output logic [1:0]        fwd_a_sel_o,
   output logic [1:0]        fwd_b_sel_o,
   output logic [DATA_W-1:0] fwd_a_o,
   output logic [DATA_W-1:0] fwd_b_o,
   output logic              wb_we_o,
   output logic [REG_AW-1:0] wb_dest_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] dest;
      logic              use_rs;
      logic              use_rt;
      logic              wb_en;
      logic              is_load;
   } slot_t;

   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   slot_t            ex_q, ex_d, mem_q, wb_q;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic             hit_ex, hit_mem, hit_wb;
   logic             stall, flush;

   function automatic logic src_hit(slot_t s, logic use_rs, logic [REG_AW-1:0] rs,
                                    logic use_rt, logic [REG_AW-1:0] rt);
      return s.valid && s.wb_en && (s.dest != '0) &&
             ((use_rs && (s.dest == rs)) || (use_rt && (s.dest == rt)));
   endfunction

   // Loads in MEM have no data yet, so only the WB slot may forward a load result.
   function automatic logic [1:0] fwd_sel(slot_t mem, slot_t wb, logic use_src,
                                          logic [REG_AW-1:0] src);
      logic [1:0] sel;
      sel = 2'd0;
      if (FWD_EN != 0 && use_src) begin
         if (mem.valid && mem.wb_en && !mem.is_load && (mem.dest != '0) && (mem.dest == src)) begin
            sel = 2'd1;
         end else if (wb.valid && wb.wb_en && (wb.dest != '0) && (wb.dest == src)) begin
            sel = 2'd2;
         end
      end
      return sel;
   endfunction

   assign hit_ex  = src_hit(ex_q,  id_use_rs_i, id_rs_i, id_use_rt_i, id_rt_i);
   assign hit_mem = src_hit(mem_q, id_use_rs_i, id_rs_i, id_use_rt_i, id_rt_i);
   assign hit_wb  = src_hit(wb_q,  id_use_rs_i, id_rs_i, id_use_rt_i, id_rt_i);

   always_comb begin
      flush = ex_q.valid & ex_br_taken_i;
      if (FWD_EN != 0) begin
         stall = hit_ex & ex_q.is_load & ~flush;
      end else begin
         stall = (hit_ex | hit_mem | hit_wb) & ~flush;
      end

      ex_d = '0;
      if (id_valid_i && !stall && !flush) begin
         ex_d.valid   = 1'b1;
         ex_d.rs      = id_rs_i;
         ex_d.rt      = id_rt_i;
         ex_d.dest    = id_dest_i;
         ex_d.use_rs  = id_use_rs_i;
         ex_d.use_rt  = id_use_rt_i;
         ex_d.wb_en   = id_wb_en_i;
         ex_d.is_load = id_is_load_i;
      end

      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CntOne;
      flush_cnt_d = flush_cnt_q;
      if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CntOne;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= ex_q;
         wb_q        <= mem_q;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign fwd_a_sel_o = fwd_sel(mem_q, wb_q, ex_q.use_rs, ex_q.rs);
   assign fwd_b_sel_o = fwd_sel(mem_q, wb_q, ex_q.use_rt, ex_q.rt);

   always_comb begin
      fwd_a_o = ex_rs_data_i;
      case (fwd_a_sel_o)
         2'd1:    fwd_a_o = mem_alu_data_i;
         2'd2:    fwd_a_o = wb_data_i;
         default: fwd_a_o = ex_rs_data_i;
      endcase
      fwd_b_o = ex_rt_data_i;
      case (fwd_b_sel_o)
         2'd1:    fwd_b_o = mem_alu_data_i;
         2'd2:    fwd_b_o = wb_data_i;
         default: fwd_b_o = ex_rt_data_i;
      endcase
   end

   assign stall_o     = stall;
   assign flush_o     = flush;
   assign wb_we_o     = wb_q.valid & wb_q.wb_en & (wb_q.dest != '0);
   assign wb_dest_o   = wb_q.dest;
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

   // Source fields of the later slots are tracked but not consulted.
   logic unused_slot_bits;
   assign unused_slot_bits = ^{mem_q.rs, mem_q.rt, mem_q.use_rs, mem_q.use_rt,
                               wb_q.rs, wb_q.rt, wb_q.use_rs, wb_q.use_rt, wb_q.is_load};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic against a slot-list
// model, run on a forwarding instance (u1) and a stall-only instance with 3-bit counters (u0).
module tb_pipe_hazard_ctrl;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW1 = 16;
   localparam int CW0 = 3;
   localparam int Max1 = (1 << CW1) - 1;
   localparam int Max0 = (1 << CW0) - 1;

   typedef struct packed {
      logic          valid;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic [AW-1:0] dest;
      logic          use_rs;
      logic          use_rt;
      logic          wb_en;
      logic          is_load;
   } instr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0, id_wb_en = 1'b0, id_is_load = 1'b0;
   logic [AW-1:0] id_rs = '0, id_rt = '0, id_dest = '0;
   logic ex_br_taken = 1'b0;
   logic [DW-1:0] ex_rs_data = '0, ex_rt_data = '0, mem_alu_data = '0, wb_data = '0;

   logic stall1, flush1, we1, stall0, flush0, we0;
   logic [1:0] sela1, selb1, sela0, selb0;
   logic [DW-1:0] fa1, fb1, fa0, fb0;
   logic [AW-1:0] wd1, wd0;
   logic [CW1-1:0] sc1, fc1;
   logic [CW0-1:0] sc0, fc0;

   int n_chk = 0;
   int n_fail = 0;

   instr_t cur;
   instr_t m1[3];
   instr_t m0[3];
   int sc1_m, fc1_m, sc0_m, fc0_m;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.DATA_W(DW), .REG_AW(AW), .FWD_EN(1), .CNT_W(CW1)) u1 (
      .clk(clk), .rst_n(rst_n),
      .id_valid_i(id_valid), .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt),
      .id_wb_en_i(id_wb_en), .id_is_load_i(id_is_load),
      .id_rs_i(id_rs), .id_rt_i(id_rt), .id_dest_i(id_dest), .ex_br_taken_i(ex_br_taken),
      .ex_rs_data_i(ex_rs_data), .ex_rt_data_i(ex_rt_data),
      .mem_alu_data_i(mem_alu_data), .wb_data_i(wb_data),
      .stall_o(stall1), .flush_o(flush1), .fwd_a_sel_o(sela1), .fwd_b_sel_o(selb1),
      .fwd_a_o(fa1), .fwd_b_o(fb1), .wb_we_o(we1), .wb_dest_o(wd1),
      .stall_cnt_o(sc1), .flush_cnt_o(fc1)
   );

   pipe_hazard_ctrl #(.DATA_W(DW), .REG_AW(AW), .FWD_EN(0), .CNT_W(CW0)) u0 (
      .clk(clk), .rst_n(rst_n),
      .id_valid_i(id_valid), .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt),
      .id_wb_en_i(id_wb_en), .id_is_load_i(id_is_load),
      .id_rs_i(id_rs), .id_rt_i(id_rt), .id_dest_i(id_dest), .ex_br_taken_i(ex_br_taken),
      .ex_rs_data_i(ex_rs_data), .ex_rt_data_i(ex_rt_data),
      .mem_alu_data_i(mem_alu_data), .wb_data_i(wb_data),
      .stall_o(stall0), .flush_o(flush0), .fwd_a_sel_o(sela0), .fwd_b_sel_o(selb0),
      .fwd_a_o(fa0), .fwd_b_o(fb0), .wb_we_o(we0), .wb_dest_o(wd0),
      .stall_cnt_o(sc0), .flush_cnt_o(fc0)
   );

   // ---------------- reference model ----------------
   function automatic bit writes_src(instr_t s, instr_t id);
      return s.valid && s.wb_en && s.dest != 0 &&
             ((id.use_rs && s.dest == id.rs) || (id.use_rt && s.dest == id.rt));
   endfunction

   function automatic bit m_stall(bit fwd, instr_t ex, instr_t mem, instr_t wb, instr_t id,
                                  bit br);
      if (ex.valid && br) return 1'b0;
      if (fwd) return writes_src(ex, id) && ex.is_load;
      return writes_src(ex, id) || writes_src(mem, id) || writes_src(wb, id);
   endfunction

   function automatic logic [1:0] m_sel(bit fwd, instr_t ex, instr_t mem, instr_t wb, bit b);
      logic [AW-1:0] src;
      bit u;
      src = b ? ex.rt : ex.rs;
      u = b ? ex.use_rt : ex.use_rs;
      if (!fwd || !u || src == 0) return 2'd0;
      if (mem.valid && mem.wb_en && !mem.is_load && mem.dest == src) return 2'd1;
      if (wb.valid && wb.wb_en && wb.dest == src) return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic [DW-1:0] m_data(logic [1:0] sel, logic [DW-1:0] regval);
      if (sel == 2'd1) return mem_alu_data;
      if (sel == 2'd2) return wb_data;
      return regval;
   endfunction

   function automatic instr_t mk(bit ld, int dest, int rs, int rt, bit urs, bit urt);
      instr_t i;
      i.valid = 1'b1;
      i.is_load = ld;
      i.wb_en = 1'b1;
      i.dest = AW'(dest);
      i.rs = AW'(rs);
      i.rt = AW'(rt);
      i.use_rs = urs;
      i.use_rt = urt;
      return i;
   endfunction

   task automatic set_id(instr_t i);
      cur = i;
      id_valid = i.valid;
      id_use_rs = i.use_rs;
      id_use_rt = i.use_rt;
      id_wb_en = i.wb_en;
      id_is_load = i.is_load;
      id_rs = i.rs;
      id_rt = i.rt;
      id_dest = i.dest;
   endtask

   task automatic rand_data();
      ex_rs_data = $urandom;
      ex_rt_data = $urandom;
      mem_alu_data = $urandom;
      wb_data = $urandom;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 3; i++) begin
         m1[i] = '0;
         m0[i] = '0;
      end
      sc1_m = 0; fc1_m = 0; sc0_m = 0; fc0_m = 0;
   endtask

   // One rising edge; the model shifts its slot lists using pre-edge decisions.
   task automatic tick();
      bit s1, f1, s0, f0;
      s1 = m_stall(1'b1, m1[0], m1[1], m1[2], cur, ex_br_taken);
      f1 = m1[0].valid && ex_br_taken;
      s0 = m_stall(1'b0, m0[0], m0[1], m0[2], cur, ex_br_taken);
      f0 = m0[0].valid && ex_br_taken;
      @(posedge clk);
      m1[2] = m1[1]; m1[1] = m1[0]; m1[0] = (s1 || f1 || !cur.valid) ? '0 : cur;
      m0[2] = m0[1]; m0[1] = m0[0]; m0[0] = (s0 || f0 || !cur.valid) ? '0 : cur;
      if (s1 && sc1_m < Max1) sc1_m++;
      if (f1 && fc1_m < Max1) fc1_m++;
      if (s0 && sc0_m < Max0) sc0_m++;
      if (f0 && fc0_m < Max0) fc0_m++;
      #1;
   endtask

   task automatic do_reset();
      set_id('0);
      ex_br_taken = 1'b0;
      rst_n = 1'b0;
      model_clear();
      #2;
      rst_n = 1'b1;
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      ex_br_taken = 1'b1;
      set_id(mk(1, 3, 3, 3, 1, 1));
      #1;
      n_chk++; if ({stall1, flush1} !== 2'b00) begin
         n_fail++; $display("FAIL reset_stall_flush: got %b expected 00", {stall1, flush1});
      end
      n_chk++; if ({sela1, selb1, sela0, selb0} !== 8'h00) begin
         n_fail++; $display("FAIL reset_sels: got %h expected 00", {sela1, selb1, sela0, selb0});
      end
      n_chk++; if ({we1, wd1, we0, wd0} !== '0) begin
         n_fail++; $display("FAIL reset_wb: got %h expected 0", {we1, wd1, we0, wd0});
      end
      n_chk++; if ({sc1, fc1, sc0, fc0} !== '0) begin
         n_fail++; $display("FAIL reset_cnt: got %h expected 0", {sc1, fc1, sc0, fc0});
      end
      ex_br_taken = 1'b0;
      set_id('0);
      model_clear();
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_fwd_mem();
      do_reset();
      set_id(mk(0, 3, 1, 2, 1, 1)); tick();
      set_id(mk(0, 4, 3, 1, 1, 1)); rand_data(); #1;
      n_chk++; if (stall1 !== 1'b0) begin
         n_fail++; $display("FAIL fwd_mem_nostall: got %b expected 0", stall1);
      end
      tick();
      set_id('0); rand_data(); #1;
      n_chk++; if (sela1 !== 2'd1 || fa1 !== mem_alu_data) begin
         n_fail++; $display("FAIL fwd_mem_a: got sel %0d data %h expected sel 1 data %h",
                            sela1, fa1, mem_alu_data);
      end
      n_chk++; if (selb1 !== 2'd0 || fb1 !== ex_rt_data) begin
         n_fail++; $display("FAIL fwd_mem_b: got sel %0d data %h expected sel 0 data %h",
                            selb1, fb1, ex_rt_data);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(mk(1, 2, 1, 0, 1, 0)); tick();
      set_id(mk(0, 5, 2, 2, 1, 1)); #1;
      n_chk++; if (stall1 !== 1'b1) begin
         n_fail++; $display("FAIL load_use_stall: got %b expected 1", stall1);
      end
      tick(); #1;
      n_chk++; if (stall1 !== 1'b0) begin
         n_fail++; $display("FAIL load_use_one_cycle: got %b expected 0", stall1);
      end
      tick();
      set_id('0); rand_data(); #1;
      n_chk++; if (sela1 !== 2'd2 || selb1 !== 2'd2 || fa1 !== wb_data) begin
         n_fail++; $display("FAIL load_use_wb_fwd: got sels %0d/%0d data %h expected 2/2 %h",
                            sela1, selb1, fa1, wb_data);
      end
      n_chk++; if (sc1 !== 16'd1) begin
         n_fail++; $display("FAIL load_use_cnt: got %0d expected 1", sc1);
      end
   endtask

   task automatic test_priority();
      do_reset();
      set_id(mk(0, 3, 1, 2, 1, 1)); tick();
      set_id(mk(0, 3, 4, 5, 1, 1)); tick();
      set_id(mk(0, 6, 3, 3, 1, 1)); tick();
      set_id('0); rand_data(); #1;
      n_chk++; if (sela1 !== 2'd1 || selb1 !== 2'd1 || fa1 !== mem_alu_data) begin
         n_fail++; $display("FAIL mem_over_wb: got sels %0d/%0d data %h expected 1/1 %h",
                            sela1, selb1, fa1, mem_alu_data);
      end
      do_reset();
      set_id(mk(0, 0, 1, 2, 1, 1)); tick();
      set_id(mk(0, 7, 0, 0, 1, 1)); #1;
      n_chk++; if (stall0 !== 1'b0) begin
         n_fail++; $display("FAIL r0_nostall: got %b expected 0", stall0);
      end
      tick();
      set_id('0); rand_data(); #1;
      n_chk++; if (sela1 !== 2'd0 || selb1 !== 2'd0 || fa1 !== ex_rs_data) begin
         n_fail++; $display("FAIL r0_nofwd: got sels %0d/%0d data %h expected 0/0 %h",
                            sela1, selb1, fa1, ex_rs_data);
      end
   endtask

   task automatic test_flush();
      do_reset();
      set_id(mk(1, 2, 1, 0, 1, 0)); tick();
      set_id(mk(0, 5, 2, 2, 1, 1)); ex_br_taken = 1'b1; #1;
      n_chk++; if ({flush1, stall1} !== 2'b10) begin
         n_fail++; $display("FAIL flush_priority: got flush,stall %b expected 10", {flush1, stall1});
      end
      tick();
      set_id('0); #1;
      n_chk++; if (flush1 !== 1'b0) begin
         n_fail++; $display("FAIL flush_bubble: got %b expected 0", flush1);
      end
      n_chk++; if (fc1 !== 16'd1 || sc1 !== 16'd0) begin
         n_fail++; $display("FAIL flush_cnt: got flush %0d stall %0d expected 1 0", fc1, sc1);
      end
      ex_br_taken = 1'b0;
   endtask

   task automatic test_nofwd();
      do_reset();
      set_id(mk(0, 3, 1, 2, 1, 1)); tick();
      set_id(mk(0, 4, 3, 3, 1, 1));
      for (int i = 0; i < 4; i++) begin
         rand_data(); #1;
         n_chk++; if (stall0 !== (i < 3)) begin
            n_fail++; $display("FAIL nofwd_stall[%0d]: got %b expected %b", i, stall0, i < 3);
         end
         n_chk++; if ({sela0, selb0} !== 4'h0) begin
            n_fail++; $display("FAIL nofwd_sels[%0d]: got %h expected 0", i, {sela0, selb0});
         end
         tick();
      end
      set_id('0); rand_data(); #1;
      n_chk++; if (sc0 !== 3'd3 || fa0 !== ex_rs_data) begin
         n_fail++; $display("FAIL nofwd_cnt: got cnt %0d data %h expected 3 %h",
                            sc0, fa0, ex_rs_data);
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      set_id(mk(1, 3, 1, 2, 1, 1)); tick();
      set_id(mk(0, 4, 3, 3, 1, 1)); #1;
      n_chk++; if ({stall1, stall0} !== 2'b11) begin
         n_fail++; $display("FAIL mid_stall_pre: got %b expected 11", {stall1, stall0});
      end
      tick();
      rst_n = 1'b0;
      model_clear();
      #1;
      n_chk++; if ({stall1, stall0, flush1, flush0} !== 4'b0000) begin
         n_fail++; $display("FAIL mid_stall_abort: got %b expected 0000",
                            {stall1, stall0, flush1, flush0});
      end
      n_chk++; if ({sc1, sc0, we1, we0, wd1, wd0} !== '0) begin
         n_fail++; $display("FAIL mid_stall_clear: got %h expected 0", {sc1, sc0, we1, we0, wd1, wd0});
      end
      #1;
      rst_n = 1'b1;
      #1;
      tick(); #1;
      n_chk++; if ({stall1, stall0} !== 2'b00 || sc0 !== 3'd0) begin
         n_fail++; $display("FAIL mid_stall_residual: got stall %b cnt %0d expected 00 0",
                            {stall1, stall0}, sc0);
      end
   endtask

   task automatic test_random();
      instr_t r;
      logic [1:0] a, b;
      logic [107:0] obs1, exp1;
      logic [81:0] obs0, exp0;
      bit s, f;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         r.valid = ($urandom % 4) != 0;
         r.rs = AW'($urandom % 4);
         r.rt = AW'($urandom % 4);
         r.dest = AW'($urandom % 4);
         r.use_rs = $urandom % 2;
         r.use_rt = $urandom % 2;
         r.wb_en = ($urandom % 4) != 0;
         r.is_load = ($urandom % 3) == 0;
         set_id(r);
         ex_br_taken = ($urandom % 6) == 0;
         rand_data();
         #1;
         s = m_stall(1'b1, m1[0], m1[1], m1[2], cur, ex_br_taken);
         f = m1[0].valid && ex_br_taken;
         a = m_sel(1'b1, m1[0], m1[1], m1[2], 1'b0);
         b = m_sel(1'b1, m1[0], m1[1], m1[2], 1'b1);
         exp1 = {s, f, a, b, m_data(a, ex_rs_data), m_data(b, ex_rt_data),
                 m1[2].valid && m1[2].wb_en && m1[2].dest != 0, m1[2].dest,
                 CW1'(sc1_m), CW1'(fc1_m)};
         obs1 = {stall1, flush1, sela1, selb1, fa1, fb1, we1, wd1, sc1, fc1};
         n_chk++; if (obs1 !== exp1) begin
            n_fail++; $display("FAIL random_fwd[%0d]: got %h expected %h", n, obs1, exp1);
         end
         s = m_stall(1'b0, m0[0], m0[1], m0[2], cur, ex_br_taken);
         f = m0[0].valid && ex_br_taken;
         exp0 = {s, f, 4'h0, ex_rs_data, ex_rt_data,
                 m0[2].valid && m0[2].wb_en && m0[2].dest != 0, m0[2].dest,
                 CW0'(sc0_m), CW0'(fc0_m)};
         obs0 = {stall0, flush0, sela0, selb0, fa0, fb0, we0, wd0, sc0, fc0};
         n_chk++; if (obs0 !== exp0) begin
            n_fail++; $display("FAIL random_stall_only[%0d]: got %h expected %h", n, obs0, exp0);
         end
         tick();
      end
      ex_br_taken = 1'b0;
   endtask

   initial begin
      model_clear();
      test_reset();
      test_fwd_mem();
      test_load_use();
      test_priority();
      test_flush();
      test_nofwd();
      test_reset_mid_stall();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/forward data width.
REQ-002 SHALL have parameter REG_AW, default 5, register-index width.
REQ-003 SHALL have parameter FWD_EN, default 1; 1 = forwarding enabled, 0 = stall-only mode.
REQ-004 SHALL have parameter CNT_W, default 16, performance-counter width.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have ports id_valid in 1, id_use_rs in 1, id_use_rt in 1, id_wb_en in 1, id_is_load in 1, describing the instruction in ID.
REQ-008 SHALL have ports id_rs, id_rt, id_dest, input, REG_AW, giving the ID instruction's source and destination indices.
REQ-009 SHALL have port ex_br_taken, input, 1, meaning the branch in EX resolved taken (beq or bne).
REQ-010 SHALL have ports ex_rs_data, ex_rt_data, mem_alu_data, wb_data, input, DATA_W, giving register-file operands latched in ID/EX, the EX/MEM ALU result and the MEM/WB write-back value.
REQ-011 SHALL have ports stall, output, 1, holding PC and IF/ID; and flush, output, 1, clearing IF/ID.
REQ-012 SHALL have ports fwd_a_sel, fwd_b_sel, output, 2, with encodings 0 = regfile, 1 = MEM, 2 = WB.
REQ-013 SHALL have ports fwd_a, fwd_b, output, DATA_W, carrying the selected EX operands.
REQ-014 SHALL have ports wb_we, output, 1, and wb_dest, output, REG_AW, carrying the register-file write enable and index from the WB slot.
REQ-015 SHALL have ports stall_cnt, flush_cnt, output, CNT_W, as performance counters.

Function
REQ-016 SHALL keep three tracking slots, EX, MEM and WB, each holding valid, rs, rt, use_rs, use_rt, dest, wb_en and is_load.
REQ-017 SHALL advance the slots each cycle as ID->EX->MEM->WB, with the WB contents discarded.
REQ-018 SHALL load the EX slot with an invalid bubble when stall or flush is asserted, or when id_valid=0.
REQ-019 SHALL define a slot hazard match as: slot valid, wb_en=1, dest!=0, and dest equal to a used ID source (id_use_rs/id_rs or id_use_rt/id_rt).
REQ-020 In FWD_EN=1, SHALL assert stall (combinational) only on a match with the EX slot where EX is_load=1, giving a 1-cycle load-use bubble.
REQ-021 In FWD_EN=0, SHALL assert stall on a match with any of the EX, MEM or WB slots, and SHALL hold it until no match remains (up to 3 cycles).
REQ-022 SHALL assert flush (combinational) when ex_br_taken=1 and the EX slot is valid.
REQ-023 On flush, SHALL place a bubble in EX at the next edge, discarding the ID instruction.
REQ-024 SHALL force stall=0 whenever flush=1 (flush priority).
REQ-025 SHALL set fwd_a_sel=1 when the MEM slot is valid, wb_en=1, is_load=0, dest!=0, dest==EX rs and EX use_rs=1.
REQ-026 Otherwise, SHALL set fwd_a_sel=2 when the WB slot is valid, wb_en=1, dest!=0, dest==EX rs and EX use_rs=1.
REQ-027 Otherwise, SHALL set fwd_a_sel=0.
REQ-028 SHALL apply the rules of REQ-025 to REQ-027 to fwd_b_sel using EX rt/use_rt.
REQ-029 SHALL give MEM priority over WB when both match.
REQ-030 In FWD_EN=0, SHALL tie fwd_a_sel and fwd_b_sel to 0.
REQ-031 SHALL drive fwd_a and fwd_b combinationally from ex_rs/ex_rt_data (sel 0), mem_alu_data (sel 1) or wb_data (sel 2).
REQ-032 SHALL drive wb_we = WB valid & wb_en & (dest!=0), and wb_dest = WB dest.
REQ-033 SHALL increment stall_cnt once per cycle with stall=1, saturating at all-ones.
REQ-034 SHALL increment flush_cnt once per cycle with flush=1, saturating at all-ones.
REQ-035 SHALL never forward and never stall on register 0.
REQ-036 SHALL have no combinational path from ex_br_taken to the fwd_a_sel/fwd_b_sel outputs.

Reset
REQ-037 On rst_n=0, SHALL asynchronously clear all slot valid bits and both counters.
REQ-038 While in reset, SHALL drive stall=0, flush=0, fwd_a_sel=fwd_b_sel=0, wb_we=0 and wb_dest=0.
REQ-039 On reset assertion mid-stall or mid-flush, SHALL abort the operation with no residual bubble after release.
REQ-040 SHALL resume normal advance on the first rising edge after rst_n deasserts.

Verification
REQ-041 SHALL cover: add r3 then sub r4,r3,r1 back-to-back with FWD_EN=1 -> no stall, fwd_a_sel=1, fwd_a=mem_alu_data.
REQ-042 SHALL cover: lw r2 then add r5,r2,r2 -> stall=1 for exactly 1 cycle; then fwd_a_sel=fwd_b_sel=2, fwd_a=wb_data; stall_cnt=1.
REQ-043 SHALL cover: r3 written by both the MEM and WB slots with an EX reader -> fwd_a_sel=1 (MEM wins); dest=r0 -> fwd_a_sel=0.
REQ-044 SHALL cover: ex_br_taken=1 coinciding with a load-use match -> flush=1, stall=0, EX bubble next cycle, flush_cnt=1.
REQ-045 SHALL cover: FWD_EN=0 with add r3 then add r4,r3,r3 -> stall held 3 cycles, fwd sels remain 0.
REQ-046 SHALL cover: rst_n pulsed low during a stall -> stall=0 immediately, all slots invalid, counters=0.
